// File: rtl/dtree_pkg.sv
// Shared decision-tree definitions: node record sizing, field offsets and the
// node-memory state encoding, used by tree_mem, the controller and benches.
package dtree_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

    function automatic int aw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int node_size_f(input int features, input int coeff_w, input int bias_w);
        return 3 + features + (features - 1) * coeff_w + bias_w;
    endfunction

    function automatic int wpn_f(input int node_size, input int cfg_w);
        return (node_size + cfg_w - 1) / cfg_w;
    endfunction

    // Record layout, LSB upward: bias, coefficients, feature mask, one-position, child flags.
    function automatic int bias_off_f();
        return 0;
    endfunction

    function automatic int coeff_off_f(input int i, input int coeff_w, input int bias_w);
        return bias_w + i * coeff_w;
    endfunction

    function automatic int feat_off_f(input int features, input int coeff_w, input int bias_w);
        return bias_w + (features - 1) * coeff_w;
    endfunction

    function automatic int one_pos_off_f(input int features, input int coeff_w, input int bias_w);
        return feat_off_f(features, coeff_w, bias_w) + features;
    endfunction

    function automatic int child_flags_off_f(input int features, input int coeff_w, input int bias_w);
        return one_pos_off_f(features, coeff_w, bias_w) + 1;
    endfunction

endpackage

// File: rtl/tree_mem_if.sv
// Node-read and config-load bus between the tree controller (master) and the
// node memory (slave).
interface tree_mem_if
    import dtree_pkg::*;
#(
    parameter int FEATURES      = 3,
    parameter int COEFF_WIDTH   = 4,
    parameter int BIAS_WIDTH    = 10,
    parameter int MAX_CLUSTERS  = 5,
    parameter int CHANNEL_COUNT = 1,
    parameter int CFG_WIDTH     = 8
);
    localparam int NODE_SIZE = node_size_f(FEATURES, COEFF_WIDTH, BIAS_WIDTH);
    localparam int NODE_AW   = aw_f(MAX_CLUSTERS);
    localparam int CH_AW     = aw_f(CHANNEL_COUNT);

    logic [CH_AW-1:0]     ch_index;
    logic [NODE_AW-1:0]   node_index;
    logic                 read_mem;
    logic [NODE_SIZE-1:0] node_data;
    logic                 mem_ready;
    logic                 cfg_start;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 cfg_error;

    modport master (
        output ch_index, node_index, read_mem, cfg_start, cfg_valid, cfg_data,
        input  node_data, mem_ready, cfg_ready, cfg_error
    );

    modport slave (
        input  ch_index, node_index, read_mem, cfg_start, cfg_valid, cfg_data,
        output node_data, mem_ready, cfg_ready, cfg_error
    );

endinterface

// File: rtl/cfg_deserializer.sv
// Collects WPN config words MSB-first into one node record and strobes
// record_valid the cycle after the last word of the record is accepted.
module cfg_deserializer
    import dtree_pkg::*;
#(
    parameter int CFG_WIDTH = 8,
    parameter int WPN       = 3,
    parameter int NODE_SIZE = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 word_valid,
    input  logic [CFG_WIDTH-1:0] word_data,
    output logic [NODE_SIZE-1:0] record,
    output logic                 record_valid
);
    localparam int SR_W = WPN * CFG_WIDTH;
    localparam int WC_W = aw_f(WPN);

    logic [SR_W-1:0] shreg_r;
    logic [SR_W-1:0] shreg_next_s;
    logic [WC_W-1:0] word_cnt_r;
    logic            record_valid_r;

    generate
        if (WPN == 1) begin : g_single
            assign shreg_next_s = word_data;
        end else begin : g_multi
            assign shreg_next_s = {shreg_r[SR_W-CFG_WIDTH-1:0], word_data};
        end
    endgenerate

    // Shift in accepted words and count them off into whole records.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg_r        <= '0;
            word_cnt_r     <= '0;
            record_valid_r <= 1'b0;
        end else begin
            record_valid_r <= 1'b0;
            if (word_valid) begin
                shreg_r <= shreg_next_s;
                if (word_cnt_r == WC_W'(WPN - 1)) begin
                    word_cnt_r     <= '0;
                    record_valid_r <= 1'b1;
                end else begin
                    word_cnt_r <= word_cnt_r + WC_W'(1);
                end
            end
        end
    end

    // Leading pad bits of the first word fall off the top here.
    assign record       = shreg_r[NODE_SIZE-1:0];
    assign record_valid = record_valid_r;

endmodule

// File: rtl/tree_mem.sv
// Node memory for the decision-tree controller, loaded word-serially at run time.
// Optional load checksum word enabled by defining TREE_MEM_CHECKSUM_EN.
module tree_mem
    import dtree_pkg::*;
#(
    parameter int FEATURES      = 3,
    parameter int COEFF_WIDTH   = 4,
    parameter int BIAS_WIDTH    = 10,
    parameter int MAX_CLUSTERS  = 5,
    parameter int NODES_PER_CH  = 5,
    parameter int CHANNEL_COUNT = 1,
    parameter int CFG_WIDTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    tree_mem_if.slave  bus
);
    localparam int NODE_SIZE   = node_size_f(FEATURES, COEFF_WIDTH, BIAS_WIDTH);
    localparam int WPN         = wpn_f(NODE_SIZE, CFG_WIDTH);
    localparam int TOTAL_NODES = CHANNEL_COUNT * NODES_PER_CH;
    localparam int TOTAL_WORDS = TOTAL_NODES * WPN;
`ifdef TREE_MEM_CHECKSUM_EN
    localparam int LAST_WORD   = TOTAL_WORDS;
`else
    localparam int LAST_WORD   = TOTAL_WORDS - 1;
`endif
    localparam int MEM_AW      = aw_f(TOTAL_NODES);
    localparam int WC_W        = aw_f(TOTAL_WORDS + 1);

    logic [NODE_SIZE-1:0] mem_r [TOTAL_NODES];

    state_e               state_r;
    logic                 mem_ready_r;
    logic                 cfg_ready_r;
    logic [NODE_SIZE-1:0] node_data_r;
    logic [WC_W-1:0]      word_cnt_r;
    logic [MEM_AW-1:0]    node_cnt_r;
`ifdef TREE_MEM_CHECKSUM_EN
    logic                 cfg_error_r;
    logic [CFG_WIDTH-1:0] xor_r;
`endif

    logic                 accept_s;
    logic                 deser_valid_s;
    logic                 wr_en_s;
    logic [NODE_SIZE-1:0] record_s;
    logic                 record_valid_s;
    logic                 rd_in_range_s;
    logic [MEM_AW-1:0]    rd_addr_s;

    // Word acceptance, record write enable and read address decode.
    always_comb begin
        accept_s      = bus.cfg_valid && cfg_ready_r && !bus.cfg_start;
        deser_valid_s = accept_s && (word_cnt_r < WC_W'(TOTAL_WORDS));
        wr_en_s       = record_valid_s && !bus.cfg_start && (state_r == LOAD);
        rd_in_range_s = (32'(bus.ch_index) < 32'(CHANNEL_COUNT)) &&
                        (32'(bus.node_index) < 32'(NODES_PER_CH));
        rd_addr_s     = MEM_AW'(32'(bus.ch_index) * 32'(NODES_PER_CH) + 32'(bus.node_index));
    end

    cfg_deserializer #(
        .CFG_WIDTH (CFG_WIDTH),
        .WPN       (WPN),
        .NODE_SIZE (NODE_SIZE)
    ) u_deser (
        .clk          (clk),
        .reset        (reset),
        .clear        (bus.cfg_start),
        .word_valid   (deser_valid_s),
        .word_data    (bus.cfg_data),
        .record       (record_s),
        .record_valid (record_valid_s)
    );

    // Record storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[node_cnt_r] <= record_s;
        end
    end

    // Load/serve state machine with all bus outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mem_ready_r <= 1'b0;
            cfg_ready_r <= 1'b0;
            node_data_r <= '0;
            word_cnt_r  <= '0;
            node_cnt_r  <= '0;
`ifdef TREE_MEM_CHECKSUM_EN
            cfg_error_r <= 1'b0;
            xor_r       <= '0;
`endif
        end else if (bus.cfg_start) begin
            state_r     <= LOAD;
            mem_ready_r <= 1'b0;
            cfg_ready_r <= 1'b1;
            word_cnt_r  <= '0;
            node_cnt_r  <= '0;
`ifdef TREE_MEM_CHECKSUM_EN
            cfg_error_r <= 1'b0;
            xor_r       <= '0;
`endif
            if (bus.read_mem) begin
                node_data_r <= '0;
            end
        end else begin
            case (state_r)
                LOAD: begin
                    if (bus.read_mem) begin
                        node_data_r <= '0;
                    end
                    if (accept_s) begin
                        word_cnt_r <= word_cnt_r + WC_W'(1);
                        if (word_cnt_r == WC_W'(LAST_WORD)) begin
                            cfg_ready_r <= 1'b0;
                        end
                    end
                    if (record_valid_s && (node_cnt_r != MEM_AW'(TOTAL_NODES - 1))) begin
                        node_cnt_r <= node_cnt_r + MEM_AW'(1);
                    end
`ifdef TREE_MEM_CHECKSUM_EN
                    if (accept_s) begin
                        xor_r <= xor_r ^ bus.cfg_data;
                    end
                    // The checksum word is the XOR of every data word before it.
                    if (accept_s && (word_cnt_r == WC_W'(TOTAL_WORDS))) begin
                        if (xor_r == bus.cfg_data) begin
                            state_r     <= READY;
                            mem_ready_r <= 1'b1;
                        end else begin
                            state_r     <= IDLE;
                            cfg_error_r <= 1'b1;
                        end
                    end
`else
                    if (record_valid_s && (node_cnt_r == MEM_AW'(TOTAL_NODES - 1))) begin
                        state_r     <= READY;
                        mem_ready_r <= 1'b1;
                    end
`endif
                end
                READY: begin
                    if (bus.read_mem) begin
                        node_data_r <= rd_in_range_s ? mem_r[rd_addr_s] : '0;
                    end
                end
                IDLE: begin
                    if (bus.read_mem) begin
                        node_data_r <= '0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem_ready_r <= 1'b0;
                    cfg_ready_r <= 1'b0;
                    node_data_r <= '0;
                end
            endcase
        end
    end

    assign bus.node_data = node_data_r;
    assign bus.mem_ready = mem_ready_r;
    assign bus.cfg_ready = cfg_ready_r;
`ifdef TREE_MEM_CHECKSUM_EN
    assign bus.cfg_error = cfg_error_r;
`else
    assign bus.cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_tree_mem.sv
// Directed bench for tree_mem: reset, load, read/hold, abort and reload.
module tb_tree_mem;
    import dtree_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [7:0] xsum;

    tree_mem_if bus ();

    tree_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        xsum = 8'h00;
    endtask

    task automatic send_word(input logic [7:0] w);
        int budget;
        budget = 20;
        bus.cfg_data  = w;
        bus.cfg_valid = 1'b1;
        while (!bus.cfg_ready && budget > 0) begin
            tick();
            budget--;
        end
        check_val("cfg_ready_wait", 32'(bus.cfg_ready), 32'd1);
        tick();
        bus.cfg_valid = 1'b0;
        xsum = xsum ^ w;
    endtask

    task automatic load_words(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            send_word(base + 8'(i));
        end
    endtask

    task automatic finish_load(input string tag);
`ifdef TREE_MEM_CHECKSUM_EN
        send_word(xsum);
        check_val({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'd1);
        check_val({tag, "_cfg_error"}, 32'(bus.cfg_error), 32'd0);
`else
        check_val({tag, "_ready_early"}, 32'(bus.mem_ready), 32'd0);
        check_val({tag, "_cfg_ready_drop"}, 32'(bus.cfg_ready), 32'd0);
        tick();
        check_val({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'd1);
        check_val({tag, "_cfg_error"}, 32'(bus.cfg_error), 32'd0);
`endif
    endtask

    task automatic do_read(input logic ch, input logic [2:0] node, input string tag,
                           input logic [31:0] exp);
        bus.ch_index   = ch;
        bus.node_index = node;
        bus.read_mem   = 1'b1;
        tick();
        bus.read_mem   = 1'b0;
        check_val(tag, 32'(bus.node_data), exp);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        xsum           = 8'h00;
        reset          = 1'b1;
        bus.ch_index   = 1'b0;
        bus.node_index = 3'd0;
        bus.read_mem   = 1'b0;
        bus.cfg_start  = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_data   = 8'h00;
        repeat (3) tick();
        check_val("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        check_val("rst_node_data", 32'(bus.node_data), 32'd0);
        check_val("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check_val("rst_cfg_error", 32'(bus.cfg_error), 32'd0);

        // Reads and stray config words before any load.
        reset         = 1'b0;
        bus.read_mem  = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("idle_node_data", 32'(bus.node_data), 32'd0);
            check_val("idle_mem_ready", 32'(bus.mem_ready), 32'd0);
            check_val("idle_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        end
        bus.read_mem  = 1'b0;
        bus.cfg_valid = 1'b0;

        // First full load of words 0x01..0x0F.
        start_pulse();
        check_val("ld_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check_val("ld_mem_ready_low", 32'(bus.mem_ready), 32'd0);
        load_words(8'h01, 15);
        finish_load("ld1");

        do_read(1'b0, 3'd0, "rd_node0", 32'h010203);
        do_read(1'b0, 3'd4, "rd_node4", 32'h0D0E0F);
        do_read(1'b0, 3'd2, "rd_node2", 32'h070809);
        do_read(1'b0, 3'd5, "rd_node5_oor", 32'h000000);
        do_read(1'b0, 3'd7, "rd_node7_oor", 32'h000000);
        do_read(1'b1, 3'd0, "rd_ch1_oor", 32'h000000);

        // Hold with read_mem low while the address moves.
        do_read(1'b0, 3'd1, "rd_node1", 32'h040506);
        bus.node_index = 3'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("hold_node1", 32'(bus.node_data), 32'h040506);
        end

        // Back-to-back reads every cycle.
        bus.read_mem   = 1'b1;
        bus.node_index = 3'd0;
        tick();
        check_val("b2b_node0", 32'(bus.node_data), 32'h010203);
        bus.node_index = 3'd3;
        tick();
        check_val("b2b_node3", 32'(bus.node_data), 32'h0A0B0C);
        bus.node_index = 3'd4;
        tick();
        check_val("b2b_node4", 32'(bus.node_data), 32'h0D0E0F);
        bus.read_mem   = 1'b0;

        // Abort mid-load: word 7 arrives together with cfg_start and is dropped.
        start_pulse();
        check_val("abort_ready_fall", 32'(bus.mem_ready), 32'd0);
        load_words(8'h11, 6);
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h17;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        xsum          = 8'h00;
        check_val("abort_mem_ready", 32'(bus.mem_ready), 32'd0);
        load_words(8'h21, 14);
        check_val("abort_partial", 32'(bus.mem_ready), 32'd0);
        send_word(8'h2F);
        finish_load("ld2");
        do_read(1'b0, 3'd0, "abort_node0", 32'h212223);
        do_read(1'b0, 3'd4, "abort_node4", 32'h2D2E2F);

        // Restart while READY: reads return zero until the reload completes.
        start_pulse();
        check_val("restart_mem_ready", 32'(bus.mem_ready), 32'd0);
        do_read(1'b0, 3'd0, "restart_read", 32'h000000);
        load_words(8'h01, 15);
        finish_load("ld3");
        do_read(1'b0, 3'd4, "reload_node4", 32'h0D0E0F);

`ifdef TREE_MEM_CHECKSUM_EN
        // Corrupted checksum word must fail the load.
        start_pulse();
        load_words(8'h01, 15);
        send_word(xsum ^ 8'h01);
        check_val("cks_bad_error", 32'(bus.cfg_error), 32'd1);
        check_val("cks_bad_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        check_val("cks_bad_error_hold", 32'(bus.cfg_error), 32'd1);
        do_read(1'b0, 3'd0, "cks_bad_read", 32'h000000);
        start_pulse();
        check_val("cks_error_clear", 32'(bus.cfg_error), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
